// File: rtl/rc4_key_checker.sv
// rc4_key_checker: runs RC4 (KSA + PRGA) for one candidate key against the
// encrypted message ROM, writes the decrypted bytes to the result RAM and
// reports whether every byte is lowercase a-z or space.
module rc4_key_checker #(
    parameter int unsigned MSG_LEN   = 32,
    parameter int unsigned KEY_BYTES = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         reset_all,
    input  logic [8*KEY_BYTES-1:0]       secret_key,
    output logic [7:0]                   s_addr,
    output logic [7:0]                   s_wrdata,
    output logic                         s_wren,
    input  logic [7:0]                   s_rddata,
    output logic [$clog2(MSG_LEN)-1:0]   e_addr,
    input  logic [7:0]                   e_rddata,
    output logic [$clog2(MSG_LEN)-1:0]   d_addr,
    output logic [7:0]                   d_wrdata,
    output logic                         d_wren,
    output logic                         failure,
    output logic                         success
);

    localparam int unsigned AW = $clog2(MSG_LEN);
    localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [4:0] {
        IDLE, INIT,
        SH_RDI, SH_CAPI, SH_RDJ, SH_CAPJ, SH_WRI, SH_WRJ,
        DC_RDI, DC_CAPI, DC_RDJ, DC_CAPJ, DC_WRI, DC_WRJ,
        DC_RDF, DC_CAPF, DC_CHK,
        DONE
    } state_t;

    state_t                 state_q;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [7:0]             i_q, j_q, si_q, sj_q, byte_q;
    logic [AW-1:0]          k_q;
    logic [KW-1:0]          km_q;     // i mod KEY_BYTES during the shuffle
    logic [7:0]             s_addr_q, s_wrdata_q, d_wrdata_q;
    logic                   s_wren_q, d_wren_q;
    logic [AW-1:0]          e_addr_q, d_addr_q;
    logic                   failure_q, success_q;
    logic [7:0]             key_byte_c;

    function automatic logic is_valid(input logic [7:0] b);
        return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

    // Select key byte i mod KEY_BYTES (byte 0 is the most significant)
    always_comb begin
        key_byte_c = 8'h00;
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (km_q == KW'(n)) key_byte_c = key_q[8*(KEY_BYTES-1-n) +: 8];
        end
    end

    // Main sequencer; every memory strobe and result flag is registered
    always_ff @(posedge clk) begin
        if (!reset || !reset_all) begin
            state_q    <= IDLE;
            key_q      <= '0;
            i_q        <= 8'h00;
            j_q        <= 8'h00;
            si_q       <= 8'h00;
            sj_q       <= 8'h00;
            byte_q     <= 8'h00;
            k_q        <= '0;
            km_q       <= '0;
            s_addr_q   <= 8'h00;
            s_wrdata_q <= 8'h00;
            s_wren_q   <= 1'b0;
            e_addr_q   <= '0;
            d_addr_q   <= '0;
            d_wrdata_q <= 8'h00;
            d_wren_q   <= 1'b0;
            failure_q  <= 1'b0;
            success_q  <= 1'b0;
        end else begin
            s_wren_q <= 1'b0;
            d_wren_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    key_q      <= secret_key;
                    i_q        <= 8'h00;
                    j_q        <= 8'h00;
                    k_q        <= '0;
                    km_q       <= '0;
                    s_addr_q   <= 8'h00;
                    s_wrdata_q <= 8'h00;
                    s_wren_q   <= 1'b1;
                    state_q    <= INIT;
                end
                INIT: begin
                    if (i_q == 8'hFF) begin
                        i_q     <= 8'h00;
                        j_q     <= 8'h00;
                        km_q    <= '0;
                        state_q <= SH_RDI;
                    end else begin
                        i_q        <= i_q + 8'd1;
                        s_addr_q   <= i_q + 8'd1;
                        s_wrdata_q <= i_q + 8'd1;
                        s_wren_q   <= 1'b1;
                    end
                end
                SH_RDI: begin
                    s_addr_q <= i_q;
                    state_q  <= SH_CAPI;
                end
                SH_CAPI: begin
                    si_q    <= s_rddata;
                    j_q     <= j_q + s_rddata + key_byte_c;
                    state_q <= SH_RDJ;
                end
                SH_RDJ: begin
                    s_addr_q <= j_q;
                    state_q  <= SH_CAPJ;
                end
                SH_CAPJ: begin
                    sj_q    <= s_rddata;
                    state_q <= SH_WRI;
                end
                SH_WRI: begin
                    s_addr_q   <= i_q;
                    s_wrdata_q <= sj_q;
                    s_wren_q   <= 1'b1;
                    state_q    <= SH_WRJ;
                end
                SH_WRJ: begin
                    s_addr_q   <= j_q;
                    s_wrdata_q <= si_q;
                    s_wren_q   <= 1'b1;
                    km_q       <= (km_q == KW'(KEY_BYTES-1)) ? '0 : km_q + KW'(1);
                    if (i_q == 8'hFF) begin
                        i_q     <= 8'h00;
                        j_q     <= 8'h00;
                        state_q <= DC_RDI;
                    end else begin
                        i_q     <= i_q + 8'd1;
                        state_q <= SH_RDI;
                    end
                end
                DC_RDI: begin
                    i_q      <= i_q + 8'd1;
                    s_addr_q <= i_q + 8'd1;
                    state_q  <= DC_CAPI;
                end
                DC_CAPI: begin
                    si_q    <= s_rddata;
                    j_q     <= j_q + s_rddata;
                    state_q <= DC_RDJ;
                end
                DC_RDJ: begin
                    s_addr_q <= j_q;
                    state_q  <= DC_CAPJ;
                end
                DC_CAPJ: begin
                    sj_q    <= s_rddata;
                    state_q <= DC_WRI;
                end
                DC_WRI: begin
                    s_addr_q   <= i_q;
                    s_wrdata_q <= sj_q;
                    s_wren_q   <= 1'b1;
                    state_q    <= DC_WRJ;
                end
                DC_WRJ: begin
                    s_addr_q   <= j_q;
                    s_wrdata_q <= si_q;
                    s_wren_q   <= 1'b1;
                    state_q    <= DC_RDF;
                end
                DC_RDF: begin
                    s_addr_q <= si_q + sj_q;
                    e_addr_q <= k_q;
                    state_q  <= DC_CAPF;
                end
                DC_CAPF: begin
                    byte_q     <= s_rddata ^ e_rddata;
                    d_addr_q   <= k_q;
                    d_wrdata_q <= s_rddata ^ e_rddata;
                    d_wren_q   <= 1'b1;
                    state_q    <= DC_CHK;
                end
                DC_CHK: begin
                    if (!is_valid(byte_q)) begin
                        failure_q <= 1'b1;
                        state_q   <= DONE;
                    end else if (k_q == AW'(MSG_LEN-1)) begin
                        success_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        k_q     <= k_q + AW'(1);
                        state_q <= DC_RDI;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_addr   = s_addr_q;
    assign s_wrdata = s_wrdata_q;
    assign s_wren   = s_wren_q;
    assign e_addr   = e_addr_q;
    assign d_addr   = d_addr_q;
    assign d_wrdata = d_wrdata_q;
    assign d_wren   = d_wren_q;
    assign failure  = failure_q;
    assign success  = success_q;

endmodule

// File: tb/tb_rc4_key_checker.sv
// Bench for rc4_key_checker: behavioural memories around the DUT and a plain
// RC4 reference computed with integer arrays.
module tb_rc4_key_checker;

    logic        clk, reset, reset_all;
    logic [23:0] secret_key;
    logic [7:0]  s_addr, s_wrdata, s_rddata;
    logic        s_wren;
    logic [4:0]  e_addr, d_addr;
    logic [7:0]  e_rddata, d_wrdata;
    logic        d_wren, failure, success;

    logic [7:0]  s_mem [256];
    logic [7:0]  e_rom [32];
    logic [7:0]  d_mem [32];
    logic [7:0]  ks_ref [32];
    logic [7:0]  plain [32];
    int          s_wr_cnt, d_wr_cnt;
    int          n_cmp, n_bad;

    rc4_key_checker #(.MSG_LEN(32), .KEY_BYTES(3)) dut (
        .clk(clk), .reset(reset), .reset_all(reset_all), .secret_key(secret_key),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_rddata(s_rddata),
        .e_addr(e_addr), .e_rddata(e_rddata),
        .d_addr(d_addr), .d_wrdata(d_wrdata), .d_wren(d_wren),
        .failure(failure), .success(success)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read memories: the DUT address is already registered
    assign s_rddata = s_mem[s_addr];
    assign e_rddata = e_rom[e_addr];

    always @(posedge clk) begin
        if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
            s_wr_cnt      <= s_wr_cnt + 1;
        end
        if (d_wren) begin
            d_mem[d_addr] <= d_wrdata;
            d_wr_cnt      <= d_wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Textbook RC4 keystream for a 3-byte key
    task automatic rc4_ref(input logic [23:0] key);
        int sb [256];
        int kb [3];
        int i, j, t;
        kb[0] = int'(key[23:16]);
        kb[1] = int'(key[15:8]);
        kb[2] = int'(key[7:0]);
        for (int n = 0; n < 256; n++) sb[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + sb[n] + kb[n % 3]) % 256;
            t = sb[n]; sb[n] = sb[j]; sb[j] = t;
        end
        i = 0;
        j = 0;
        for (int k = 0; k < 32; k++) begin
            i = (i + 1) % 256;
            j = (j + sb[i]) % 256;
            t = sb[i]; sb[i] = sb[j]; sb[j] = t;
            ks_ref[k] = 8'(sb[(sb[i] + sb[j]) % 256]);
        end
    endtask

    function automatic logic printable(input logic [7:0] b);
        return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

    // Index of the first byte of e_rom^ks_ref that is not printable, or -1
    function automatic int first_bad();
        for (int n = 0; n < 32; n++) begin
            if (!printable(e_rom[n] ^ ks_ref[n])) return n;
        end
        return -1;
    endfunction

    function automatic logic [7:0] rand_char();
        int c;
        c = int'($urandom_range(0, 26));
        return (c == 26) ? 8'h20 : 8'(8'h61 + c);
    endfunction

    // Drop the run strobe for one edge
    task automatic stop_run();
        @(negedge clk);
        reset_all = 1'b0;
        tick();
    endtask

    // Start a run, wait for a result and compare against the reference model
    task automatic run_check(input logic [23:0] key, input string tag);
        int c, exp_k, exp_c, last, d0, bad;
        rc4_ref(key);
        exp_k = first_bad();
        exp_c = (exp_k < 0) ? 2080 : 1792 + 9 * (exp_k + 1);
        d0    = d_wr_cnt;
        @(negedge clk);
        secret_key = key;
        reset_all  = 1'b1;
        tick();
        check({tag, "_first_s_write"}, {s_wren, s_addr, s_wrdata}, {1'b1, 8'h00, 8'h00});
        c = 0;
        while (!(failure || success) && c <= 3000) begin
            tick();
            c++;
            if (c == 5) secret_key = 24'($urandom);
        end
        check({tag, "_latency"}, c, exp_c);
        check({tag, "_success"}, success, (exp_k < 0));
        check({tag, "_failure"}, failure, (exp_k >= 0));
        last = (exp_k < 0) ? 31 : exp_k;
        check({tag, "_d_writes"}, d_wr_cnt - d0, last + 1);
        bad = 0;
        for (int n = 0; n <= last; n++) begin
            if (d_mem[n] !== (e_rom[n] ^ ks_ref[n])) bad++;
        end
        check({tag, "_d_ram"}, bad, 0);
    endtask

    // Fill the ROM so that the given key decrypts it to the given bytes
    task automatic load_rom(input logic [23:0] key, input logic [7:0] pt [32]);
        rc4_ref(key);
        for (int n = 0; n < 32; n++) e_rom[n] = pt[n] ^ ks_ref[n];
    endtask

    initial begin
        logic [7:0]  crafted [32];
        logic [7:0]  pat [3];
        logic [23:0] rk;
        int          bad, d0, s0, hold_ok, kbad;

        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b0;
        reset_all  = 1'b0;
        secret_key = 24'h0;
        for (int n = 0; n < 32; n++) e_rom[n] = 8'h00;
        repeat (3) tick();
        check("rst_flags", {failure, success}, 2'b00);
        check("rst_wren", {s_wren, d_wren}, 2'b00);
        check("rst_addr", {s_addr, e_addr, d_addr}, 18'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("idle_hold", {failure, success, s_wren, d_wren}, 4'b0000);

        // INIT fills S with the identity
        d0 = d_wr_cnt;
        @(negedge clk);
        secret_key = 24'h000000;
        reset_all  = 1'b1;
        tick();
        repeat (256) tick();
        bad = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== 8'(n)) bad++;
        check("init_sbox", bad, 0);
        check("init_no_d_write", d_wr_cnt - d0, 0);
        check("init_end_wren", s_wren, 1'b0);
        stop_run();

        // Correct key against a random lowercase/space message
        for (int n = 0; n < 32; n++) plain[n] = rand_char();
        load_rom(24'h000249, plain);
        run_check(24'h000249, "good_key");
        bad = 0;
        for (int n = 0; n < 32; n++) if (d_mem[n] !== plain[n]) bad++;
        check("good_plaintext", bad, 0);

        // Results hold in DONE with no memory traffic
        s0 = s_wr_cnt;
        d0 = d_wr_cnt;
        hold_ok = 1;
        repeat (100) begin
            tick();
            if (!(success === 1'b1 && failure === 1'b0 && s_wren === 1'b0 && d_wren === 1'b0))
                hold_ok = 0;
        end
        check("hold_levels", hold_ok, 1);
        check("hold_writes", (s_wr_cnt - s0) + (d_wr_cnt - d0), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("reset_clears", {success, failure, s_wren, d_wren, s_addr}, 12'h000);
        @(negedge clk);
        reset_all = 1'b0;
        reset     = 1'b1;
        tick();

        // Wrong key on the same ROM
        run_check(24'h000248, "wrong_key");
        stop_run();

        // Boundary bytes just outside the printable range in the last slot
        pat[0] = 8'h7A; pat[1] = 8'h61; pat[2] = 8'h20;
        rk = 24'($urandom);
        for (int n = 0; n < 31; n++) crafted[n] = pat[n % 3];
        crafted[31] = 8'h7B;
        load_rom(rk, crafted);
        run_check(rk, "bound_7b");
        stop_run();
        crafted[31] = 8'h60;
        load_rom(rk, crafted);
        run_check(rk, "bound_60");
        stop_run();

        // NUL at a random position in an otherwise valid message
        rk   = 24'($urandom);
        kbad = int'($urandom_range(1, 30));
        for (int n = 0; n < 32; n++) crafted[n] = (n == kbad) ? 8'h00 : rand_char();
        load_rom(rk, crafted);
        run_check(rk, "nul_byte");
        stop_run();

        // Random key against a random ROM
        for (int n = 0; n < 32; n++) e_rom[n] = 8'($urandom);
        run_check(24'($urandom), "rand_rom");
        stop_run();

        // Abort in the middle of the shuffle, then restart with the correct key
        load_rom(24'h000249, plain);
        @(negedge clk);
        secret_key = 24'($urandom);
        reset_all  = 1'b1;
        tick();
        repeat (999) tick();
        @(negedge clk);
        reset_all = 1'b0;
        tick();
        check("abort_flags", {failure, success}, 2'b00);
        check("abort_wren_addr", {s_wren, d_wren, s_addr}, 10'h000);
        run_check(24'h000249, "abort_restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rc4_key_checker.md
# rc4_key_checker

Responder side of the key-search handshake: accepts a 24-bit candidate key and a run strobe from the key-search controller, runs RC4 (KSA + PRGA) against the encrypted message ROM, and writes the decrypted bytes to the result RAM. It reports `failure` on the first non-printable byte and `success` if every byte is lowercase `a`–`z` or space. It sits between the key-search controller and three on-chip memories: S-box RAM, encrypted ROM and decrypted RAM.

## Interface
- `MSG_LEN`, 32, message length in bytes (address width 5).
- `KEY_BYTES`, 3, key length in bytes; key byte 0 = `secret_key[23:16]`, 1 = `[15:8]`, 2 = `[7:0]`.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low; forces IDLE and clears all outputs.
- `reset_all` in 1: run strobe; 0 = hold/restart, 1 = run.
- `secret_key` in 24: candidate key; latched on the start edge.
- `s_addr` out 8, `s_wrdata` out 8, `s_wren` out 1, `s_rddata` in 8: S-box RAM port.
- `e_addr` out 5, `e_rddata` in 8: encrypted message ROM.
- `d_addr` out 5, `d_wrdata` out 8, `d_wren` out 1: decrypted message RAM.
- `failure` out 1, `success` out 1: result levels, mutually exclusive.

## Operation
- Memories are synchronous-read. An address registered at edge k gives data that is sampled at edge k+1. Writes occur at the edge where `wren` is high.
- States: IDLE, INIT, SH_RDI, SH_CAPI, SH_RDJ, SH_CAPJ, SH_WRI, SH_WRJ, DC_RDI, DC_CAPI, DC_RDJ, DC_CAPJ, DC_WRI, DC_WRJ, DC_RDF, DC_CAPF, DC_CHK, DONE.
- IDLE: `reset_all`=1 at an edge latches `secret_key`, clears i, j, k and enters INIT (the start edge).
- INIT: write S[i]=i, one write per cycle for i=0..255. The i wrap to 0 enters SH_RDI with j=0.
- SHUFFLE (6 cycles/iteration):
  - read S[i] and capture it.
  - j = j + S[i] + key[i mod 3], all mod 256.
  - read S[j] and capture it.
  - write S[i]=S[j], then write S[j]=S[i].
  - i=255 ends the phase with i=0, j=0.
  - i==j needs no special case.
- DECRYPT, per k=0..31 (9 cycles/byte):
  - i=i+1; read and capture S[i].
  - j=j+S[i]; read and capture S[j].
  - swap as in SHUFFLE.
  - DC_RDF drives `s_addr`=S[i]+S[j] and `e_addr`=k together; DC_CAPF captures f and e.
  - DC_CHK writes d[k]=f^e. If the byte is valid it increments k; otherwise it sets `failure` and goes to DONE.
  - After DC_CHK for k=31 with all bytes valid: set `success` and go to DONE.
- DONE: outputs held, no memory writes, until `reset_all`=0.
- Valid byte: 8'h61..8'h7A or 8'h20. Any byte fails, including NUL.
- All index arithmetic is 8-bit wrap-around. k is 5-bit.

## Timing
- Reset values (on `reset`=0 or `reset_all`=0 sampled at an edge): `failure`=0, `success`=0, all `wren`=0, all addresses=0, state IDLE. This takes effect at that edge.
- `reset_all`=0 mid-operation aborts in any state. The S contents are don't-care. The next start re-runs INIT from address 0 with the newly latched key.
- `reset`=0 has priority over `reset_all`.
- Latency from the start edge E0:
  - INIT ends at E0+256.
  - SHUFFLE ends at E0+1792.
  - `success` high at E0+2080.
  - `failure` on byte k high at E0+1792+9(k+1).
- `failure`/`success` are level signals. They stay high until cleared, so a controller that waits several cycles still sees them.
- `secret_key` changes after the start edge are ignored.

## Test plan
- INIT check: key 24'h000000, `reset_all` raised; hold the bench at E0+256 -> S[n]=n for all n, no prior d writes.
- Correct key: ROM = RC4(24'h000249, 32-byte lowercase/space text) -> `success`=1 exactly at E0+2080, `failure` never 1, d RAM equals the plaintext.
- Wrong key: same ROM, key 24'h000248 -> `failure`=1 at E0+1792+9(k+1), where k is the first invalid byte index per the bench model; `success` stays 0.
- Boundary bytes: ROM crafted so bytes 0..30 decrypt to 8'h7A/8'h61/8'h20 and byte 31 to 8'h7B -> `failure` at E0+2080. A second run with byte 31 = 8'h60 gives the same result.
- Abort: drop `reset_all` at E0+1000 (SHUFFLE) for 1 cycle, then raise it with a new key -> outputs 0 at the next edge; the next S write is address 0 with data 0; full-length run completes with the correct result for the new key.
- Hold and reset: after `success`, keep `reset_all`=1 for 100 cycles -> `success` stays 1 with no `wren`. Then `reset`=0 -> `success`=0 at that edge, state IDLE.
